// File: rtl/onehot_req_arbiter_pkg.sv
// Shared types and constants for the one-hot request arbiter and its
// round-robin picker.
package arb_pkg;

    localparam int unsigned N     = 8;
    localparam int unsigned PTR_W = 3;

    typedef enum logic {
        IDLE,
        OFFER
    } state_t;

    localparam logic [N-1:0] GRANT_RST   = '0;
    localparam logic [N-1:0] PENDING_RST = '0;

    // Index of the set bit in a one-hot vector; zero for an all-zero vector.
    function automatic logic [PTR_W-1:0] onehot_idx(input logic [N-1:0] v);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (v[i]) begin
                idx = idx | PTR_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/onehot_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of cand at or after ptr,
// wrapping from the top bit back to bit 0.
module rr_pick
    import arb_pkg::*;
(
    input  logic [N-1:0]     cand,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     sel,
    output logic             any
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [N-1:0]   low;
    logic [2*N-1:0] back;

    always_comb begin
        // Rotate so ptr lands on bit 0, isolate lowest set bit, rotate back.
        dbl  = {cand, cand} >> ptr;
        rot  = dbl[N-1:0];
        low  = rot & (~rot + 1'b1);
        back = {low, low} << ptr;
        sel  = back[2*N-1:N];
        any  = |cand;
    end

endmodule

// File: rtl/onehot_req_arbiter.sv
// Request collector and round-robin arbiter presenting one strictly one-hot
// grant at a time over a valid/ready handshake.
module onehot_req_arbiter
    import arb_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_in,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [N-1:0] grant,
    output logic [N-1:0] pending,
    output logic         ovf
);

    state_t           state;
    logic [PTR_W-1:0] ptr;

    logic             acc;
    logic             hold;
    logic [PTR_W-1:0] ptr_adv;
    logic [PTR_W-1:0] pick_ptr;
    logic [N-1:0]     cand;
    logic [N-1:0]     dup;
    logic [N-1:0]     sel;
    logic             any;

    assign out_valid = (state == OFFER);

    always_comb begin
        acc      = out_valid & out_ready;
        hold     = out_valid & ~out_ready;
        ptr_adv  = onehot_idx(grant) + 1'b1;
        // On accept the search already starts past the accepted bit, so a
        // same-cycle re-request of that bit ranks lowest.
        pick_ptr = acc ? ptr_adv : ptr;
        cand     = pending | req_in;
        dup      = req_in & (pending | (hold ? grant : '0));
    end

    rr_pick u_pick (
        .cand (cand),
        .ptr  (pick_ptr),
        .sel  (sel),
        .any  (any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            grant   <= GRANT_RST;
            pending <= PENDING_RST;
            ptr     <= '0;
            ovf     <= 1'b0;
        end else begin
            if (|dup) begin
                ovf <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (any) begin
                        state   <= OFFER;
                        grant   <= sel;
                        pending <= cand & ~sel;
                    end
                end
                OFFER: begin
                    if (!out_ready) begin
                        pending <= cand & ~grant;
                    end else begin
                        ptr <= ptr_adv;
                        if (any) begin
                            grant   <= sel;
                            pending <= cand & ~sel;
                        end else begin
                            state   <= IDLE;
                            grant   <= GRANT_RST;
                            pending <= PENDING_RST;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
